// File: rtl/regfile_mt_pkg.sv
// regfile_mt_pkg: shared definitions for the multithreaded register file.
//   - Width constants shared with the writeback stage.
//   - xcpt_type_t: exception cause encoding stored in rm2.
//   - is_reg_zero(): helper for the hard-wired zero register.
package regfile_mt_pkg;

    localparam int THR_PER_CORE        = 4;   // hardware threads per core
    localparam int RF_ADDR_RANGE       = 5;   // architectural register address bits
    localparam int REG_FILE_DATA_RANGE = 32;  // register data bits
    localparam int ROB_ID_RANGE        = 4;   // ROB instruction-id bits
    localparam int PC_RANGE            = 32;  // exception PC bits
    localparam int XCPT_TYPE_RANGE     = 2;   // exception cause bits

    typedef enum logic [XCPT_TYPE_RANGE-1:0] {
        XCPT_NONE    = 2'd0,
        XCPT_ILLEGAL = 2'd1,
        XCPT_MEM     = 2'd2,
        XCPT_SYSCALL = 2'd3
    } xcpt_type_t;

    // Register 0 is hard-wired to zero and never tracked as pending.
    function automatic logic is_reg_zero(input logic [RF_ADDR_RANGE-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-thread pending bits and producer ROB tags.
//   clock/reset        : core clock, synchronous active-high reset
//   commit_*           : committed write; clears pend when the tag matches
//   alloc_*            : decode rename; sets pend and records the producer tag
//   flush              : per-thread flush, clears every pend bit of the thread
//   rd_thread/rd_src*  : read address for both decode ports
//   pend*/tag*         : stored scoreboard state (no same-cycle forwarding)
// Priority at a register: flush > alloc > commit clear.
module regfile_scoreboard
    import regfile_mt_pkg::*;
#(
    parameter  int NUM_THREADS = THR_PER_CORE,
    parameter  int NUM_REGS    = 1 << RF_ADDR_RANGE,
    parameter  int ROB_ID_W    = ROB_ID_RANGE,
    localparam int THR_W       = $clog2(NUM_THREADS),
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   commit_valid,
    input  logic [THR_W-1:0]       commit_thread,
    input  logic [ADDR_W-1:0]      commit_dest,
    input  logic [ROB_ID_W-1:0]    commit_rob_id,
    input  logic                   alloc_valid,
    input  logic [THR_W-1:0]       alloc_thread,
    input  logic [ADDR_W-1:0]      alloc_dest,
    input  logic [ROB_ID_W-1:0]    alloc_rob_id,
    input  logic [NUM_THREADS-1:0] flush,
    input  logic [THR_W-1:0]       rd_thread,
    input  logic [ADDR_W-1:0]      rd_src1,
    input  logic [ADDR_W-1:0]      rd_src2,
    output logic                   pend1,
    output logic [ROB_ID_W-1:0]    tag1,
    output logic                   pend2,
    output logic [ROB_ID_W-1:0]    tag2
);

    logic [NUM_REGS-1:0] pend_q [NUM_THREADS];
    logic [ROB_ID_W-1:0] tag_q  [NUM_THREADS][NUM_REGS];

    logic commit_clear;
    logic alloc_take;

    // A commit only retires the pending state if it is from the youngest producer.
    assign commit_clear = commit_valid
                        && pend_q[commit_thread][commit_dest]
                        && (tag_q[commit_thread][commit_dest] == commit_rob_id);

    assign alloc_take = alloc_valid && (alloc_dest != '0) && !flush[alloc_thread];

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the scoreboard arrays are reset because a stale pend bit would
            // stall decode forever; this costs a reset net per flop, unlike a plain RAM.
            for (int t = 0; t < NUM_THREADS; t++) begin
                pend_q[t] <= '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    tag_q[t][r] <= '0;
                end
            end
        end else begin
            // NOTE: non-blocking assignments to the same bit resolve last-wins, so
            // the statement order below encodes the priority flush > alloc > clear.
            if (commit_clear) begin
                pend_q[commit_thread][commit_dest] <= 1'b0;
            end
            if (alloc_take) begin
                pend_q[alloc_thread][alloc_dest] <= 1'b1;
                tag_q[alloc_thread][alloc_dest]  <= alloc_rob_id;
            end
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (flush[t]) begin
                    pend_q[t] <= '0;
                end
            end
        end
    end

    assign pend1 = pend_q[rd_thread][rd_src1];
    assign tag1  = tag_q[rd_thread][rd_src1];
    assign pend2 = pend_q[rd_thread][rd_src2];
    assign tag2  = tag_q[rd_thread][rd_src2];

endmodule

// File: rtl/regfile_mt.sv
// regfile_mt: multithreaded architectural register file behind writeback.
//   clock/reset            : core clock, synchronous active-high reset
//   wr_*                   : in-order committed register write
//   xcpt_*                 : exception record, latched into rm0/rm1/rm2
//   flush                  : per-thread pipeline flush (drops pending state)
//   alloc_*                : decode rename, marks a destination pending
//   rd_thread/rd_src1/2    : decode read ports -> rd_data*, rd_pend*, rd_rob_id*
//   rm_thread              : exception register read -> rm_pc/rm_addr/rm_type/rm_valid
// Build option: define REGFILE_WR_BYPASS_EN to forward a same-cycle commit
// write to the read ports (data, and the pend bit it retires).
module regfile_mt
    import regfile_mt_pkg::*;
#(
    parameter  int NUM_THREADS = THR_PER_CORE,
    parameter  int NUM_REGS    = 1 << RF_ADDR_RANGE,
    parameter  int DATA_W      = REG_FILE_DATA_RANGE,
    parameter  int ROB_ID_W    = ROB_ID_RANGE,
    parameter  int PC_W        = PC_RANGE,
    parameter  int XCPT_TYPE_W = XCPT_TYPE_RANGE,
    localparam int THR_W       = $clog2(NUM_THREADS),
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [THR_W-1:0]       wr_thread,
    input  logic [ADDR_W-1:0]      wr_dest,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [ROB_ID_W-1:0]    wr_instr_id,
    input  logic                   xcpt_valid,
    input  logic [THR_W-1:0]       xcpt_thread,
    input  logic [XCPT_TYPE_W-1:0] xcpt_type,
    input  logic [PC_W-1:0]        xcpt_pc,
    input  logic [DATA_W-1:0]      xcpt_addr,
    input  logic [NUM_THREADS-1:0] flush,
    input  logic                   alloc_valid,
    input  logic [THR_W-1:0]       alloc_thread,
    input  logic [ADDR_W-1:0]      alloc_dest,
    input  logic [ROB_ID_W-1:0]    alloc_rob_id,
    input  logic [THR_W-1:0]       rd_thread,
    input  logic [ADDR_W-1:0]      rd_src1,
    input  logic [ADDR_W-1:0]      rd_src2,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic                   rd_pend1,
    output logic                   rd_pend2,
    output logic [ROB_ID_W-1:0]    rd_rob_id1,
    output logic [ROB_ID_W-1:0]    rd_rob_id2,
    input  logic [THR_W-1:0]       rm_thread,
    output logic [PC_W-1:0]        rm_pc,
    output logic [DATA_W-1:0]      rm_addr,
    output logic [XCPT_TYPE_W-1:0] rm_type,
    output logic                   rm_valid
);

    logic [DATA_W-1:0]      data_q    [NUM_THREADS][NUM_REGS];
    logic [PC_W-1:0]        rm_pc_q   [NUM_THREADS];
    logic [DATA_W-1:0]      rm_addr_q [NUM_THREADS];
    logic [XCPT_TYPE_W-1:0] rm_type_q [NUM_THREADS];
    logic [NUM_THREADS-1:0] rm_valid_q;

    logic                sb_pend1, sb_pend2;
    logic [ROB_ID_W-1:0] sb_tag1, sb_tag2;

    regfile_scoreboard #(
        .NUM_THREADS (NUM_THREADS),
        .NUM_REGS    (NUM_REGS),
        .ROB_ID_W    (ROB_ID_W)
    ) u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .commit_valid  (wr_en),
        .commit_thread (wr_thread),
        .commit_dest   (wr_dest),
        .commit_rob_id (wr_instr_id),
        .alloc_valid   (alloc_valid),
        .alloc_thread  (alloc_thread),
        .alloc_dest    (alloc_dest),
        .alloc_rob_id  (alloc_rob_id),
        .flush         (flush),
        .rd_thread     (rd_thread),
        .rd_src1       (rd_src1),
        .rd_src2       (rd_src2),
        .pend1         (sb_pend1),
        .tag1          (sb_tag1),
        .pend2         (sb_pend2),
        .tag2          (sb_tag2)
    );

    // Commit writes land regardless of flush; only the scoreboard is flushed.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    data_q[t][r] <= '0;
                end
            end
        end else if (wr_en && !is_reg_zero(wr_dest)) begin
            data_q[wr_thread][wr_dest] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                rm_pc_q[t]   <= '0;
                rm_addr_q[t] <= '0;
                rm_type_q[t] <= XCPT_TYPE_W'(XCPT_NONE);
            end
            rm_valid_q <= '0;
        end else if (xcpt_valid) begin
            rm_pc_q[xcpt_thread]    <= xcpt_pc;
            rm_addr_q[xcpt_thread]  <= xcpt_addr;
            rm_type_q[xcpt_thread]  <= xcpt_type;
            rm_valid_q[xcpt_thread] <= 1'b1;
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    logic wr_same_thread;
    assign wr_same_thread = wr_en && !is_reg_zero(wr_dest) && (wr_thread == rd_thread);
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        rd_data1   = data_q[rd_thread][rd_src1];
        rd_pend1   = sb_pend1;
        rd_rob_id1 = sb_tag1;
        rd_data2   = data_q[rd_thread][rd_src2];
        rd_pend2   = sb_pend2;
        rd_rob_id2 = sb_tag2;
`ifdef REGFILE_WR_BYPASS_EN
        // Forward the committing value; its pend bit drops only if this commit retires it.
        if (wr_same_thread && (wr_dest == rd_src1)) begin
            rd_data1 = wr_data;
            if (sb_pend1 && (sb_tag1 == wr_instr_id)) rd_pend1 = 1'b0;
        end
        if (wr_same_thread && (wr_dest == rd_src2)) begin
            rd_data2 = wr_data;
            if (sb_pend2 && (sb_tag2 == wr_instr_id)) rd_pend2 = 1'b0;
        end
`endif
        if (is_reg_zero(rd_src1)) begin
            rd_data1   = '0;
            rd_pend1   = 1'b0;
            rd_rob_id1 = '0;
        end
        if (is_reg_zero(rd_src2)) begin
            rd_data2   = '0;
            rd_pend2   = 1'b0;
            rd_rob_id2 = '0;
        end
    end

    assign rm_pc    = rm_pc_q[rm_thread];
    assign rm_addr  = rm_addr_q[rm_thread];
    assign rm_type  = rm_type_q[rm_thread];
    assign rm_valid = rm_valid_q[rm_thread];

endmodule

// File: tb/tb_regfile_mt.sv
// tb_regfile_mt: directed vector table for the multi-cycle scenarios, then
// randomized traffic compared against an array-based reference model.
// Honours REGFILE_WR_BYPASS_EN for same-cycle write forwarding expectations.
module tb_regfile_mt;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        wr_en;
        logic [1:0]  wt;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic [3:0]  wid;
        logic        xv;
        logic [1:0]  xt;
        logic [1:0]  xty;
        logic [31:0] xpc;
        logic [31:0] xad;
        logic [3:0]  fl;
        logic        av;
        logic [1:0]  at;
        logic [4:0]  ad;
        logic [3:0]  aid;
        logic [1:0]  rt;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [1:0]  rmt;
    } txn_t;

    typedef struct packed {
        txn_t        in;
        logic [31:0] d1;
        logic        p1;
        logic [3:0]  t1;
        logic [31:0] d2;
        logic        p2;
        logic [3:0]  t2;
        logic [31:0] pc;
        logic [31:0] ad;
        logic [1:0]  ty;
        logic        rv;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_thread;
    logic [4:0]  wr_dest;
    logic [31:0] wr_data;
    logic [3:0]  wr_instr_id;
    logic        xcpt_valid;
    logic [1:0]  xcpt_thread;
    logic [1:0]  xcpt_type;
    logic [31:0] xcpt_pc;
    logic [31:0] xcpt_addr;
    logic [3:0]  flush;
    logic        alloc_valid;
    logic [1:0]  alloc_thread;
    logic [4:0]  alloc_dest;
    logic [3:0]  alloc_rob_id;
    logic [1:0]  rd_thread;
    logic [4:0]  rd_src1, rd_src2;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_pend1, rd_pend2;
    logic [3:0]  rd_rob_id1, rd_rob_id2;
    logic [1:0]  rm_thread;
    logic [31:0] rm_pc;
    logic [31:0] rm_addr;
    logic [1:0]  rm_type;
    logic        rm_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_data [4][32];
    bit          m_pend [4][32];
    logic [3:0]  m_tag  [4][32];
    logic [31:0] m_pc   [4];
    logic [31:0] m_addr [4];
    logic [1:0]  m_type [4];
    bit          m_rv   [4];

    vec_t tbl [20];

    always #5 clock = ~clock;

    regfile_mt dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_thread    (wr_thread),
        .wr_dest      (wr_dest),
        .wr_data      (wr_data),
        .wr_instr_id  (wr_instr_id),
        .xcpt_valid   (xcpt_valid),
        .xcpt_thread  (xcpt_thread),
        .xcpt_type    (xcpt_type),
        .xcpt_pc      (xcpt_pc),
        .xcpt_addr    (xcpt_addr),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_thread (alloc_thread),
        .alloc_dest   (alloc_dest),
        .alloc_rob_id (alloc_rob_id),
        .rd_thread    (rd_thread),
        .rd_src1      (rd_src1),
        .rd_src2      (rd_src2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .rd_pend1     (rd_pend1),
        .rd_pend2     (rd_pend2),
        .rd_rob_id1   (rd_rob_id1),
        .rd_rob_id2   (rd_rob_id2),
        .rm_thread    (rm_thread),
        .rm_pc        (rm_pc),
        .rm_addr      (rm_addr),
        .rm_type      (rm_type),
        .rm_valid     (rm_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input txn_t x);
        reset        = x.rst;
        wr_en        = x.wr_en;
        wr_thread    = x.wt;
        wr_dest      = x.wd;
        wr_data      = x.wdat;
        wr_instr_id  = x.wid;
        xcpt_valid   = x.xv;
        xcpt_thread  = x.xt;
        xcpt_type    = x.xty;
        xcpt_pc      = x.xpc;
        xcpt_addr    = x.xad;
        flush        = x.fl;
        alloc_valid  = x.av;
        alloc_thread = x.at;
        alloc_dest   = x.ad;
        alloc_rob_id = x.aid;
        rd_thread    = x.rt;
        rd_src1      = x.s1;
        rd_src2      = x.s2;
        rm_thread    = x.rmt;
    endtask

    // Effect of one clock edge under the architectural rules.
    task automatic model_edge(input txn_t x);
        bit retire;
        if (x.rst) begin
            for (int t = 0; t < 4; t++) begin
                for (int r = 0; r < 32; r++) begin
                    m_data[t][r] = '0;
                    m_pend[t][r] = 1'b0;
                    m_tag[t][r]  = '0;
                end
                m_pc[t] = '0; m_addr[t] = '0; m_type[t] = '0; m_rv[t] = 1'b0;
            end
            return;
        end
        retire = x.wr_en && m_pend[x.wt][x.wd] && (m_tag[x.wt][x.wd] == x.wid);
        if (x.wr_en && x.wd != 0) m_data[x.wt][x.wd] = x.wdat;
        if (retire) m_pend[x.wt][x.wd] = 1'b0;
        if (x.av && x.ad != 0 && !x.fl[x.at]) begin
            m_pend[x.at][x.ad] = 1'b1;
            m_tag[x.at][x.ad]  = x.aid;
        end
        for (int t = 0; t < 4; t++) begin
            if (x.fl[t]) begin
                for (int r = 0; r < 32; r++) m_pend[t][r] = 1'b0;
            end
        end
        if (x.xv) begin
            m_pc[x.xt] = x.xpc; m_addr[x.xt] = x.xad; m_type[x.xt] = x.xty; m_rv[x.xt] = 1'b1;
        end
    endtask

    task automatic model_read(input txn_t x, input logic [4:0] s,
                              output logic [31:0] d, output logic p, output logic [3:0] tg);
        d = '0; p = 1'b0; tg = '0;
        if (s != 0) begin
            d  = m_data[x.rt][s];
            p  = m_pend[x.rt][s];
            tg = m_tag[x.rt][s];
            if (BYP && x.wr_en && x.wd == s && x.wt == x.rt) begin
                d = x.wdat;
                if (p && tg == x.wid) p = 1'b0;
            end
        end
    endtask

    task automatic check_model(input txn_t x);
        logic [31:0] d;
        logic        p;
        logic [3:0]  tg;
        model_read(x, x.s1, d, p, tg);
        check("rnd_data1", rd_data1, d);
        check("rnd_pend1", rd_pend1, p);
        if (p) check("rnd_tag1", rd_rob_id1, tg);
        model_read(x, x.s2, d, p, tg);
        check("rnd_data2", rd_data2, d);
        check("rnd_pend2", rd_pend2, p);
        if (p) check("rnd_tag2", rd_rob_id2, tg);
        check("rnd_rm_valid", rm_valid, m_rv[x.rmt]);
        check("rnd_rm_pc",    rm_pc,    m_pc[x.rmt]);
        check("rnd_rm_addr",  rm_addr,  m_addr[x.rmt]);
        check("rnd_rm_type",  rm_type,  m_type[x.rmt]);
    endtask

    function automatic txn_t rand_txn();
        txn_t x;
        x       = '0;
        x.rst   = ($urandom_range(99) == 0);
        x.wr_en = 1'($urandom_range(1));
        x.wt    = 2'($urandom_range(3));
        x.wd    = 5'($urandom_range(7));
        x.wdat  = $urandom;
        x.wid   = 4'($urandom_range(15));
        if (m_pend[x.wt][x.wd] && $urandom_range(3) != 0) x.wid = m_tag[x.wt][x.wd];
        x.xv    = ($urandom_range(7) == 0);
        x.xt    = 2'($urandom_range(3));
        x.xty   = 2'($urandom_range(3));
        x.xpc   = $urandom;
        x.xad   = $urandom;
        x.fl    = ($urandom_range(15) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0;
        x.av    = 1'($urandom_range(1));
        x.at    = 2'($urandom_range(3));
        x.ad    = 5'($urandom_range(7));
        x.aid   = 4'($urandom_range(15));
        x.rt    = 2'($urandom_range(3));
        x.s1    = 5'($urandom_range(7));
        x.s2    = 5'($urandom_range(7));
        x.rmt   = 2'($urandom_range(3));
        if ($urandom_range(1) == 1) begin
            x.rt = x.wt;
            x.s1 = x.wd;
        end
        return x;
    endfunction

    initial begin
        txn_t idle;
        txn_t x;
        idle = '0;

        // Reset for two edges; outputs are not defined before the first one.
        idle.rst = 1'b1;
        apply(idle);
        repeat (2) @(posedge clock);
        model_edge(idle);
        #1;
        idle.rst = 1'b0;

        // Directed scenarios: each row's expectations are sampled before that row's edge.
        tbl[0]  = '{in: '{rt: 0, s1: 5, default: 0}, default: 0};
        tbl[1]  = '{in: '{av: 1, at: 1, ad: 3, aid: 7, rt: 1, s1: 3, rmt: 1, default: 0}, default: 0};
        tbl[2]  = '{in: '{wr_en: 1, wt: 1, wd: 3, wdat: 32'hDEAD, wid: 7, rt: 1, s1: 3, rmt: 2, default: 0},
                    d1: BYP ? 32'hDEAD : 32'h0, p1: !BYP, t1: 7, default: 0};
        tbl[3]  = '{in: '{av: 1, at: 0, ad: 3, aid: 7, rt: 1, s1: 3, rmt: 3, default: 0},
                    d1: 32'hDEAD, default: 0};
        tbl[4]  = '{in: '{av: 1, at: 0, ad: 3, aid: 9, rt: 0, s1: 3, default: 0},
                    p1: 1, t1: 7, default: 0};
        tbl[5]  = '{in: '{wr_en: 1, wt: 0, wd: 3, wdat: 32'h11, wid: 7, rt: 0, s1: 3, default: 0},
                    d1: BYP ? 32'h11 : 32'h0, p1: 1, t1: 9, default: 0};
        tbl[6]  = '{in: '{wr_en: 1, wt: 0, wd: 3, wdat: 32'h22, wid: 9, rt: 0, s1: 3, default: 0},
                    d1: BYP ? 32'h22 : 32'h11, p1: !BYP, t1: 9, default: 0};
        tbl[7]  = '{in: '{av: 1, at: 2, ad: 4, aid: 1, rt: 0, s1: 3, default: 0},
                    d1: 32'h22, default: 0};
        tbl[8]  = '{in: '{av: 1, at: 2, ad: 6, aid: 2, rt: 2, s1: 4, s2: 6, default: 0},
                    p1: 1, t1: 1, default: 0};
        tbl[9]  = '{in: '{av: 1, at: 1, ad: 5, aid: 3, rt: 2, s1: 4, s2: 6, default: 0},
                    p1: 1, t1: 1, p2: 1, t2: 2, default: 0};
        tbl[10] = '{in: '{fl: 4'b0100, av: 1, at: 2, ad: 8, aid: 5, wr_en: 1, wt: 2, wd: 4, wdat: 5,
                          wid: 12, rt: 2, s1: 4, s2: 6, default: 0},
                    d1: BYP ? 32'h5 : 32'h0, p1: 1, t1: 1, p2: 1, t2: 2, default: 0};
        tbl[11] = '{in: '{rt: 2, s1: 4, s2: 8, default: 0}, d1: 32'h5, default: 0};
        tbl[12] = '{in: '{rt: 2, s1: 6, s2: 0, default: 0}, default: 0};
        tbl[13] = '{in: '{rt: 1, s1: 5, s2: 3, default: 0}, p1: 1, t1: 3, d2: 32'hDEAD, default: 0};
        tbl[14] = '{in: '{wr_en: 1, wt: 0, wd: 0, wdat: 32'hFF, rt: 0, s1: 0, s2: 3, default: 0},
                    d2: 32'h22, default: 0};
        tbl[15] = '{in: '{wr_en: 1, wt: 0, wd: 2, wdat: 32'h42, rt: 0, s1: 2, s2: 0, default: 0},
                    d1: BYP ? 32'h42 : 32'h0, default: 0};
        tbl[16] = '{in: '{rt: 0, s1: 2, s2: 0, default: 0}, d1: 32'h42, default: 0};
        tbl[17] = '{in: '{xv: 1, xt: 3, xpc: 32'h1000, xad: 32'h2004, xty: 2, wr_en: 1, wt: 3, wd: 1,
                          wdat: 32'h77, rt: 3, s1: 1, rmt: 3, default: 0},
                    d1: BYP ? 32'h77 : 32'h0, default: 0};
        tbl[18] = '{in: '{rt: 3, s1: 1, rmt: 3, default: 0},
                    d1: 32'h77, pc: 32'h1000, ad: 32'h2004, ty: 2, rv: 1, default: 0};
        tbl[19] = '{in: '{rt: 3, s1: 1, rmt: 0, default: 0}, d1: 32'h77, default: 0};

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].in);
            @(negedge clock);
            check($sformatf("vec%0d_data1", i), rd_data1, tbl[i].d1);
            check($sformatf("vec%0d_pend1", i), rd_pend1, tbl[i].p1);
            if (tbl[i].p1) check($sformatf("vec%0d_tag1", i), rd_rob_id1, tbl[i].t1);
            check($sformatf("vec%0d_data2", i), rd_data2, tbl[i].d2);
            check($sformatf("vec%0d_pend2", i), rd_pend2, tbl[i].p2);
            if (tbl[i].p2) check($sformatf("vec%0d_tag2", i), rd_rob_id2, tbl[i].t2);
            check($sformatf("vec%0d_rm_pc", i),    rm_pc,    tbl[i].pc);
            check($sformatf("vec%0d_rm_addr", i),  rm_addr,  tbl[i].ad);
            check($sformatf("vec%0d_rm_type", i),  rm_type,  tbl[i].ty);
            check($sformatf("vec%0d_rm_valid", i), rm_valid, tbl[i].rv);
            @(posedge clock);
            model_edge(tbl[i].in);
            #1;
        end

        // Mid-run reset: every thread's exception state and t1 pend must clear.
        x = idle;
        x.rst = 1'b1;
        apply(x);
        @(posedge clock);
        model_edge(x);
        #1;
        for (int t = 0; t < 4; t++) begin
            x = idle;
            x.rmt = 2'(t);
            x.rt  = 2'd1;
            x.s1  = 5'd5;
            x.s2  = 5'd3;
            apply(x);
            @(negedge clock);
            check($sformatf("post_reset_rm_valid_t%0d", t), rm_valid, 1'b0);
            check($sformatf("post_reset_pend_t%0d", t), rd_pend1, 1'b0);
            check($sformatf("post_reset_data_t%0d", t), rd_data2, 32'h0);
            @(posedge clock);
            model_edge(x);
            #1;
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            x = rand_txn();
            apply(x);
            @(negedge clock);
            check_model(x);
            @(posedge clock);
            model_edge(x);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
